ref_mem_burst: RTL and testbench

- Parametrised successor to the motion-estimation reference-window memory.
- NBANK pixel-column banks, each DEPTH words of PIXEL bits; one row = one word per bank at a common address.
- Multi-row reads run as a sequential burst of NROW consecutive rows into a row buffer, presented as one wide block.
- A single-row read path selects any buffered row, feeding the SAD array and fine-search stages.

---
 rtl/ref_mem_burst.sv | 130 +++++++++++++
 tb/tb_ref_mem_burst.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_mem_burst.sv
// Banked reference-window memory: NBANK pixel banks, NROW-row burst into a row buffer,
// and a single-row selector on the last completed block. Define REF_MEM_BYPASS_EN for write-first fill reads.
module ref_mem_burst #(
   parameter int PIXEL = 8,
   parameter int NBANK = 32,
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int NROW  = 8,
   parameter int SW    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NBANK*PIXEL-1:0]      ref_input,
   input  logic [NBANK-1:0]            Bank_sel,
   input  logic [NBANK*AW-1:0]         write_address_all,
   input  logic                        rd_start,
   input  logic [AW-1:0]               rd_address,
   input  logic                        rd1R_en,
   input  logic [SW-1:0]               rdR_sel,
   output logic [NROW*NBANK*PIXEL-1:0] ref_blk,
   output logic                        Oda8R_va,
   output logic                        busy,
   output logic [NBANK*PIXEL-1:0]      ref_row,
   output logic                        da1R_va
);

   localparam int            ROWW = NBANK * PIXEL;
   localparam logic [SW-1:0] LAST = SW'(NROW - 1);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t                 state_q, state_d;
   logic [AW-1:0]          base_q, base_d;
   logic [SW-1:0]          cnt_q, cnt_d;
   logic [PIXEL-1:0]       mem_q [NBANK][DEPTH];
   logic [AW-1:0]          rd_addr;
   logic [ROWW-1:0]        fill_row;
   logic [NROW*ROWW-1:0]   buf_q;
   logic [NROW*ROWW-1:0]   blk_q;
   logic [NROW*ROWW-1:0]   blk_src;
   logic [ROWW-1:0]        row_q;
   logic                   oda_q;
   logic                   da1_q;
   logic                   busy_q;
   logic                   sel_ok;

   // Bank storage: each bank writes independently of the burst FSM; out-of-range addresses drop.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NBANK; b++) begin
         if (Bank_sel[b] && (int'(write_address_all[b*AW +: AW]) < DEPTH))
            mem_q[b][write_address_all[b*AW +: AW]] <= ref_input[b*PIXEL +: PIXEL];
      end
   end

   assign rd_addr = AW'((int'(base_q) + int'(cnt_q)) % DEPTH);

   always_comb begin
      fill_row = '0;
      for (int b = 0; b < NBANK; b++) begin
         fill_row[b*PIXEL +: PIXEL] = mem_q[b][rd_addr];
`ifdef REF_MEM_BYPASS_EN
         if (Bank_sel[b] && (write_address_all[b*AW +: AW] == rd_addr))
            fill_row[b*PIXEL +: PIXEL] = ref_input[b*PIXEL +: PIXEL];
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (rd_start) begin
               state_d = FILL;
               base_d  = rd_address;
               cnt_d   = '0;
            end
         end
         FILL: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A single-row read on the DONE edge must see the block being published.
   assign blk_src = (state_q == DONE) ? buf_q : blk_q;
   assign sel_ok  = int'(rdR_sel) < NROW;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         oda_q   <= 1'b0;
         da1_q   <= 1'b0;
         buf_q   <= '0;
         blk_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != IDLE);
         oda_q   <= (state_q == DONE);
         if (state_q == FILL)
            buf_q[int'(cnt_q)*ROWW +: ROWW] <= fill_row;
         if (state_q == DONE)
            blk_q <= buf_q;
         if (rd1R_en && sel_ok) begin
            row_q <= blk_src[int'(rdR_sel)*ROWW +: ROWW];
            da1_q <= 1'b1;
         end else begin
            da1_q <= 1'b0;
         end
      end
   end

   assign ref_blk  = blk_q;
   assign Oda8R_va = oda_q;
   assign busy     = busy_q;
   assign ref_row  = row_q;
   assign da1R_va  = da1_q;

endmodule

// File: tb/tb_ref_mem_burst.sv
// Randomised bench for ref_mem_burst against a row-snapshot memory model.
module tb_ref_mem_burst;

   localparam int PIXEL = 8;
   localparam int NBANK = 32;
   localparam int DEPTH = 128;
   localparam int AW    = 7;
   localparam int NROW  = 8;
   localparam int SW    = 4;
   localparam int ROWW  = NBANK * PIXEL;

   typedef logic [ROWW-1:0] row_t;

   logic                     clk;
   logic                     rst;
   logic [ROWW-1:0]          ref_input;
   logic [NBANK-1:0]         Bank_sel;
   logic [NBANK*AW-1:0]      write_address_all;
   logic                     rd_start;
   logic [AW-1:0]            rd_address;
   logic                     rd1R_en;
   logic [SW-1:0]            rdR_sel;
   logic [NROW*ROWW-1:0]     ref_blk;
   logic                     Oda8R_va;
   logic                     busy;
   logic [ROWW-1:0]          ref_row;
   logic                     da1R_va;

   logic [PIXEL-1:0] mm [NBANK][DEPTH];
   row_t             blk_m [NROW];
   row_t             row_m;
   int               n_vec;
   int               n_err;

   ref_mem_burst #(
      .PIXEL(PIXEL), .NBANK(NBANK), .DEPTH(DEPTH), .AW(AW), .NROW(NROW), .SW(SW)
   ) dut (
      .clk(clk), .rst(rst), .ref_input(ref_input), .Bank_sel(Bank_sel),
      .write_address_all(write_address_all), .rd_start(rd_start), .rd_address(rd_address),
      .rd1R_en(rd1R_en), .rdR_sel(rdR_sel), .ref_blk(ref_blk), .Oda8R_va(Oda8R_va),
      .busy(busy), .ref_row(ref_row), .da1R_va(da1R_va)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input row_t obs, input row_t exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Bank_sel = '0;
      rd_start = 1'b0;
      rd1R_en  = 1'b0;
   endtask

   // Model side of a write edge, taken from the values currently on the write inputs.
   task automatic model_wr();
      for (int b = 0; b < NBANK; b++) begin
         if (Bank_sel[b]) begin
            int wa;
            wa = int'(write_address_all[b*AW +: AW]);
            if (wa < DEPTH) mm[b][wa] = ref_input[b*PIXEL +: PIXEL];
         end
      end
   endtask

   function automatic row_t row_of(input int a);
      row_t r;
      for (int b = 0; b < NBANK; b++) r[b*PIXEL +: PIXEL] = mm[b][a];
      return r;
   endfunction

   task automatic do_write(input logic [NBANK-1:0] sel, input int addr, input logic [PIXEL-1:0] pix);
      Bank_sel = sel;
      for (int b = 0; b < NBANK; b++) begin
         write_address_all[b*AW +: AW] = AW'(addr);
         ref_input[b*PIXEL +: PIXEL]   = pix;
      end
      model_wr();
      tick();
      Bank_sel = '0;
   endtask

   task automatic run_burst(input int base, input bit rnd_wr, input bit collide,
                            input bit restart, input int done_sel);
      row_t exp_blk [NROW];
      int   pulses;
      pulses     = 0;
      rd_address = AW'(base);
      rd_start   = 1'b1;
      tick();
      rd_start = 1'b0;
      chk("busy_start", row_t'(busy), row_t'(1));
      for (int k = 0; k < NROW; k++) begin
         int a;
         a = (base + k) % DEPTH;
         if (collide && k == 2) begin
            for (int b = 0; b < NBANK; b++) begin
               Bank_sel[b]                   = ($urandom_range(0, 3) != 0);
               write_address_all[b*AW +: AW] = AW'(a);
               ref_input[b*PIXEL +: PIXEL]   = PIXEL'($urandom);
            end
         end else if (rnd_wr) begin
            for (int b = 0; b < NBANK; b++) begin
               Bank_sel[b] = 1'($urandom_range(0, 1));
               write_address_all[b*AW +: AW] =
                  ($urandom_range(0, 1) == 1) ? AW'(a) : AW'($urandom_range(0, DEPTH - 1));
               ref_input[b*PIXEL +: PIXEL] = PIXEL'($urandom);
            end
         end
         if (restart && k == 1) begin
            rd_start   = 1'b1;
            rd_address = AW'((base + 37) % DEPTH);
         end
`ifdef REF_MEM_BYPASS_EN
         model_wr();
         exp_blk[k] = row_of(a);
`else
         exp_blk[k] = row_of(a);
         model_wr();
`endif
         tick();
         pulses += int'(Oda8R_va);
         chk("busy_fill", row_t'(busy), row_t'(1));
         idle_inputs();
      end
      chk("no_early_va", row_t'(pulses), row_t'(0));
      if (done_sel >= 0) begin
         rd1R_en = 1'b1;
         rdR_sel = SW'(done_sel);
      end
      tick();
      rd1R_en = 1'b0;
      chk("done_va", row_t'(Oda8R_va), row_t'(1));
      for (int k = 0; k < NROW; k++) begin
         blk_m[k] = exp_blk[k];
         chk($sformatf("blk_row%0d", k), ref_blk[k*ROWW +: ROWW], exp_blk[k]);
      end
      if (done_sel >= 0) begin
         if (done_sel < NROW) begin
            row_m = blk_m[done_sel];
            chk("done_rd1_va", row_t'(da1R_va), row_t'(1));
         end else begin
            chk("done_rd1_va_bad", row_t'(da1R_va), row_t'(0));
         end
         chk("done_rd1_row", ref_row, row_m);
      end
      tick();
      chk("va_end", row_t'(Oda8R_va), row_t'(0));
      chk("busy_end", row_t'(busy), row_t'(0));
   endtask

   task automatic rd1(input int sel);
      rd1R_en = 1'b1;
      rdR_sel = SW'(sel);
      tick();
      rd1R_en = 1'b0;
      if (sel < NROW) begin
         row_m = blk_m[sel];
         chk("rd1_va", row_t'(da1R_va), row_t'(1));
      end else begin
         chk("rd1_va_bad", row_t'(da1R_va), row_t'(0));
      end
      chk("rd1_row", ref_row, row_m);
      tick();
      chk("rd1_va_end", row_t'(da1R_va), row_t'(0));
   endtask

   initial begin
      row_t want;
      int   pulses;
      n_vec             = 0;
      n_err             = 0;
      rst               = 1'b1;
      ref_input         = '0;
      write_address_all = '0;
      rd_address        = '0;
      rdR_sel           = '0;
      idle_inputs();
      row_m = '0;
      for (int k = 0; k < NROW; k++) blk_m[k] = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_busy", row_t'(busy), row_t'(0));
      chk("rst_va", row_t'(Oda8R_va), row_t'(0));
      chk("rst_da1", row_t'(da1R_va), row_t'(0));
      chk("rst_row", ref_row, row_t'(0));
      chk("rst_blk0", ref_blk[0 +: ROWW], row_t'(0));

      for (int a = 0; a < DEPTH; a++) do_write('1, a, PIXEL'($urandom));

      // Rows 1..8 hold their own index; burst from 1 gives row k = k+1 everywhere.
      for (int r = 1; r <= 8; r++) do_write('1, r, PIXEL'(r));
      run_burst(1, 1'b0, 1'b0, 1'b0, -1);
      for (int k = 0; k < NROW; k++) begin
         for (int b = 0; b < NBANK; b++) want[b*PIXEL +: PIXEL] = PIXEL'(k + 1);
         chk("idx_row", ref_blk[k*ROWW +: ROWW], want);
      end

      do_write('1, 1, 8'h00);
      do_write(32'h0000_000F, 1, 8'h55);
      run_burst(1, 1'b0, 1'b0, 1'b0, -1);
      for (int b = 0; b < NBANK; b++) want[b*PIXEL +: PIXEL] = (b < 4) ? 8'h55 : 8'h00;
      chk("partial_sel", ref_blk[0 +: ROWW], want);

      for (int r = 0; r < NROW; r++) do_write('1, (DEPTH - 2 + r) % DEPTH, PIXEL'(8'hA0 + r));
      run_burst(DEPTH - 2, 1'b0, 1'b0, 1'b0, -1);
      for (int k = 0; k < NROW; k++) begin
         for (int b = 0; b < NBANK; b++) want[b*PIXEL +: PIXEL] = PIXEL'(8'hA0 + k);
         chk("wrap_row", ref_blk[k*ROWW +: ROWW], want);
      end

      run_burst(20, 1'b0, 1'b0, 1'b1, -1);
      rd1(3);
      rd1(9);
      run_burst(50, 1'b0, 1'b1, 1'b0, -1);
      run_burst(60, 1'b1, 1'b0, 1'b0, 5);

      for (int i = 0; i < 8; i++) begin
         run_burst(int'($urandom_range(0, DEPTH - 1)), 1'b1, ($urandom_range(0, 1) == 1), 1'b0,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1);
         for (int j = 0; j < 3; j++) rd1(int'($urandom_range(0, 15)));
      end

      // Reset in the middle of a fill abandons the burst and clears the published state.
      rd_address = AW'(5);
      rd_start   = 1'b1;
      tick();
      rd_start = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      row_m = '0;
      for (int k = 0; k < NROW; k++) blk_m[k] = '0;
      chk("abort_busy", row_t'(busy), row_t'(0));
      chk("abort_va", row_t'(Oda8R_va), row_t'(0));
      chk("abort_row", ref_row, row_t'(0));
      chk("abort_blk3", ref_blk[3*ROWW +: ROWW], row_t'(0));
      pulses = 0;
      repeat (NROW + 3) begin
         tick();
         pulses += int'(Oda8R_va);
      end
      chk("abort_no_va", row_t'(pulses), row_t'(0));
      run_burst(7, 1'b1, 1'b0, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
